// File: rtl/rsa_mont_arbiter.sv
// rsa_mont_arbiter
// Lets two requesters share one Montgomery multiplier in the RSA256 datapath.
// Requester 0 issues result*base, and requester 1 issues base*base.
// Each requester slot latches its operands when its start is accepted.
// A round-robin FSM then issues one operation at a time to the multiplier.
// The result goes back to the requester that issued the operation.
// A watchdog aborts an operation if the multiplier never answers.
//
// Ports
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_start0/1, i_a0/1, i_b0/1   request pulse and operands per requester
//   o_done0/1, o_result0/1       completion pulse and held result per requester
//   o_busy0/1                    requester pending or in flight
//   o_mul_start, o_mul_a/b       issue pulse and operands to the multiplier
//   i_mul_done, i_mul_result     multiplier completion pulse and result
//   o_timeout                    sticky watchdog flag, cleared only by reset

// Per-requester slot: operand latch, pending/busy flags, result register and
// done pulse. All flags are registered, so o_done and the cleared o_busy
// appear in the same cycle.
module rsa_mont_req_slot #(
    parameter int WIDTH = 256
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_grant,
    input  logic             i_cpl,
    input  logic [WIDTH-1:0] i_cpl_result,
    output logic             o_pending,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result,
    output logic [WIDTH-1:0] o_a,
    output logic [WIDTH-1:0] o_b
);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_pending <= 1'b0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_result  <= '0;
            o_a       <= '0;
            o_b       <= '0;
        end else begin
            o_done <= i_cpl;
            // Grant and completion only happen while busy, so they can never
            // coincide with an accept.
            if (i_start && !o_busy) begin
                o_a       <= i_a;
                o_b       <= i_b;
                o_pending <= 1'b1;
                o_busy    <= 1'b1;
            end else begin
                if (i_grant)
                    o_pending <= 1'b0;
                if (i_cpl) begin
                    o_busy   <= 1'b0;
                    o_result <= i_cpl_result;
                end
            end
        end
    end

endmodule

module rsa_mont_arbiter #(
    parameter int WIDTH   = 256,
    parameter int TIMEOUT = 1023
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start0,
    input  logic [WIDTH-1:0] i_a0,
    input  logic [WIDTH-1:0] i_b0,
    input  logic             i_start1,
    input  logic [WIDTH-1:0] i_a1,
    input  logic [WIDTH-1:0] i_b1,
    output logic             o_done0,
    output logic [WIDTH-1:0] o_result0,
    output logic             o_busy0,
    output logic             o_done1,
    output logic [WIDTH-1:0] o_result1,
    output logic             o_busy1,
    output logic             o_mul_start,
    output logic [WIDTH-1:0] o_mul_a,
    output logic [WIDTH-1:0] o_mul_b,
    input  logic             i_mul_done,
    input  logic [WIDTH-1:0] i_mul_result,
    output logic             o_timeout
);

    localparam int NUM_REQ = 2;
    // The counter only needs to reach TIMEOUT-1. The abort fires on the edge
    // that ends the TIMEOUT-th WAIT cycle.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] WD_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t state, state_nxt;

    logic [NUM_REQ-1:0]            start, pend, busy, done, gnt, cpl;
    logic [NUM_REQ-1:0][WIDTH-1:0] a_in, b_in, lat_a, lat_b, res;
    logic [WIDTH-1:0]              cpl_result;
    logic                          ptr;      // favoured requester on a tie
    logic                          owner;    // requester currently issued
    logic [CW-1:0]                 wd_cnt;
    logic                          wd_hit;

    assign start   = {i_start1, i_start0};
    assign a_in[0] = i_a0;
    assign a_in[1] = i_a1;
    assign b_in[0] = i_b0;
    assign b_in[1] = i_b1;

    genvar g;
    generate
        for (g = 0; g < NUM_REQ; g++) begin : g_slot
            rsa_mont_req_slot #(.WIDTH(WIDTH)) u_slot (
                .i_clk        (i_clk),
                .i_rst        (i_rst),
                .i_start      (start[g]),
                .i_a          (a_in[g]),
                .i_b          (b_in[g]),
                .i_grant      (gnt[g]),
                .i_cpl        (cpl[g]),
                .i_cpl_result (cpl_result),
                .o_pending    (pend[g]),
                .o_busy       (busy[g]),
                .o_done       (done[g]),
                .o_result     (res[g]),
                .o_a          (lat_a[g]),
                .o_b          (lat_b[g])
            );
        end
    endgenerate

    assign o_done0   = done[0];
    assign o_done1   = done[1];
    assign o_busy0   = busy[0];
    assign o_busy1   = busy[1];
    assign o_result0 = res[0];
    assign o_result1 = res[1];

    always_ff @(posedge i_clk) begin
        if (i_rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        gnt        = '0;
        cpl        = '0;
        wd_hit     = 1'b0;
        cpl_result = i_mul_result;
        case (state)
            S_IDLE: begin
                if (|pend) begin
                    state_nxt = S_ISSUE;
                    if (&pend)
                        gnt[ptr] = 1'b1;
                    else
                        gnt = pend;
                end
            end
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT: begin
                // A real done wins over an abort in the same cycle.
                if (i_mul_done) begin
                    cpl[owner] = 1'b1;
                    state_nxt  = S_IDLE;
                end else if (TIMEOUT != 0 && wd_cnt == WD_LAST) begin
                    wd_hit     = 1'b1;
                    cpl[owner] = 1'b1;
                    cpl_result = '0;
                    state_nxt  = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_mul_start <= 1'b0;
            o_mul_a     <= '0;
            o_mul_b     <= '0;
            owner       <= 1'b0;
            ptr         <= 1'b0;
            wd_cnt      <= '0;
            o_timeout   <= 1'b0;
        end else begin
            // The start pulse is registered, so it coincides with ISSUE.
            o_mul_start <= |gnt;
            if (|gnt) begin
                owner   <= gnt[1];
                ptr     <= ~gnt[1];
                o_mul_a <= lat_a[gnt[1]];
                o_mul_b <= lat_b[gnt[1]];
            end
            if (state == S_WAIT)
                wd_cnt <= wd_cnt + 1'b1;
            else
                wd_cnt <= '0;
            if (wd_hit)
                o_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rsa_mont_arbiter.sv
module tb_rsa_mont_arbiter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start0, start1;
    logic [W-1:0] a0, b0, a1, b1;
    logic         done0, done1, busy0, busy1;
    logic [W-1:0] result0, result1;
    logic         mul_start;
    logic [W-1:0] mul_a, mul_b;
    logic         mul_done;
    logic [W-1:0] mul_result;
    logic         timeout;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    rsa_mont_arbiter #(.WIDTH(W), .TIMEOUT(8)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start0     (start0),
        .i_a0         (a0),
        .i_b0         (b0),
        .i_start1     (start1),
        .i_a1         (a1),
        .i_b1         (b1),
        .o_done0      (done0),
        .o_result0    (result0),
        .o_busy0      (busy0),
        .o_done1      (done1),
        .o_result1    (result1),
        .o_busy1      (busy1),
        .o_mul_start  (mul_start),
        .o_mul_a      (mul_a),
        .o_mul_b      (mul_b),
        .i_mul_done   (mul_done),
        .i_mul_result (mul_result),
        .o_timeout    (timeout)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Bench multiplier: returns a+b four cycles after the start pulse.
    // It deliberately ignores reset, so a mid-operation reset yields a stale done.
    bit           mul_en = 1'b1;
    int           mcnt   = 0;
    logic [W-1:0] ma_l, mb_l;
    initial begin
        mul_done   = 1'b0;
        mul_result = '0;
        forever begin
            @(negedge clk);
            mul_done = 1'b0;
            if (mul_start) begin
                mcnt = 4;
                ma_l = mul_a;
                mb_l = mul_b;
            end else if (mcnt > 0) begin
                mcnt--;
                if (mcnt == 0 && mul_en) begin
                    mul_done   = 1'b1;
                    mul_result = ma_l + mb_l;
                end
            end
        end
    end

    // Pulse counters.
    int n_start = 0, n_done0 = 0, n_done1 = 0;
    initial forever begin
        @(negedge clk);
        if (mul_start) n_start++;
        if (done0)     n_done0++;
        if (done1)     n_done1++;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Issue one request and wait for its completion. All delays are measured from the start cycle.
    task automatic do_req(input bit r, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int iss, output int dn, output logic [W-1:0] ma,
                          output logic [W-1:0] mb, output logic [W-1:0] res, output bit busy_ok);
        int t0;
        @(negedge clk);
        if (r) begin start1 = 1'b1; a1 = a; b1 = b; end
        else   begin start0 = 1'b1; a0 = a; b0 = b; end
        t0 = cyc; iss = -1; dn = -1; busy_ok = 1'b1; ma = '0; mb = '0; res = '0;
        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (mul_start && iss < 0) begin
                iss = cyc - t0; ma = mul_a; mb = mul_b;
            end
            if (r ? done1 : done0) begin
                dn  = cyc - t0;
                res = r ? result1 : result0;
                if (r ? busy1 : busy0) busy_ok = 1'b0;
                break;
            end
            if (!(r ? busy1 : busy0)) busy_ok = 1'b0;
            @(negedge clk);
        end
    endtask

    // Start both requesters together. Record the issue order and the results.
    task automatic contend(input string tag);
        logic [W-1:0] ord [2];
        int k = 0, d0c = -1, s2c = -1;
        bit g0 = 0, g1 = 0;
        logic [W-1:0] r0 = '0, r1 = '0;
        ord[0] = '0; ord[1] = '0;
        @(negedge clk);
        start0 = 1'b1; a0 = 32'd1;  b0 = 32'd2;
        start1 = 1'b1; a1 = 32'd10; b1 = 32'd20;
        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0;
        for (int i = 0; i < 60 && !(g0 && g1); i++) begin
            if (mul_start && k < 2) begin
                ord[k] = mul_a;
                if (k == 1) s2c = cyc;
                k++;
            end
            if (done0) begin g0 = 1; r0 = result0; d0c = cyc; end
            if (done1) begin g1 = 1; r1 = result1; end
            @(negedge clk);
        end
        chk({tag, "_grant_first"},  ord[0], 32'd1);
        chk({tag, "_grant_second"}, ord[1], 32'd10);
        chk({tag, "_result0"}, r0, 32'd3);
        chk({tag, "_result1"}, r1, 32'd30);
        chk({tag, "_b2b_gap"}, 64'(s2c - d0c), 64'd1);
    endtask

    typedef struct {
        bit           req;
        logic [W-1:0] a, b, exp_res;
        int           exp_iss, exp_dn;
    } vec_t;

    vec_t vt [4];

    initial begin
        int iss, dn, base_s, base_d, ti;
        logic [W-1:0] ma, mb, res;
        bit bok;

        vt[0] = '{1'b0, 32'd3,          32'd5,          32'd8,          2, 7};
        vt[1] = '{1'b1, 32'd10,         32'd20,         32'd30,         2, 7};
        vt[2] = '{1'b0, 32'h8000_0000,  32'h8000_0001,  32'd1,          2, 7};
        vt[3] = '{1'b1, 32'h1234_5678,  32'h1111_1111,  32'h2345_6789,  2, 7};

        rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_flags", {busy0, busy1, done0, done1, mul_start, timeout}, 64'd0);
        chk("rst_results", {result0, result1}, 64'd0);
        chk("rst_mul_ops", {mul_a, mul_b}, 64'd0);

        // Single requests. The last entry goes to requester 1, so the pointer returns to 0.
        foreach (vt[i]) begin
            do_req(vt[i].req, vt[i].a, vt[i].b, iss, dn, ma, mb, res, bok);
            chk($sformatf("v%0d_issue_dly", i), 64'(iss), 64'(vt[i].exp_iss));
            chk($sformatf("v%0d_mul_a", i), ma, vt[i].a);
            chk($sformatf("v%0d_mul_b", i), mb, vt[i].b);
            chk($sformatf("v%0d_done_dly", i), 64'(dn), 64'(vt[i].exp_dn));
            chk($sformatf("v%0d_result", i), res, vt[i].exp_res);
            chk($sformatf("v%0d_busy", i), bok, 1'b1);
        end

        contend("cont1");
        contend("cont2");

        // A second start while busy1 is high must be ignored.
        base_s = n_start; base_d = n_done1;
        @(negedge clk);
        start1 = 1'b1; a1 = 32'd7; b1 = 32'd9;
        @(negedge clk);
        a1 = 32'd100; b1 = 32'd200;          // start1 still high, busy1 now set
        @(negedge clk);
        start1 = 1'b0;
        repeat (20) @(negedge clk);
        chk("ign_starts", 64'(n_start - base_s), 64'd1);
        chk("ign_dones",  64'(n_done1 - base_d), 64'd1);
        chk("ign_result", result1, 32'd16);
        chk("ign_mul_a",  mul_a, 32'd7);

        // Restart in the same cycle as o_done0.
        do_req(1'b0, 32'd4, 32'd4, iss, dn, ma, mb, res, bok);
        // do_req returns in the done cycle; issue the next start right here.
        start0 = 1'b1; a0 = 32'd6; b0 = 32'd7; ti = cyc;
        @(negedge clk);
        start0 = 1'b0;
        iss = -1;
        for (int k = 0; k < 10; k++) begin
            if (mul_start) begin iss = cyc - ti; break; end
            @(negedge clk);
        end
        chk("rod_issue_dly", 64'(iss), 64'd2);
        chk("rod_mul_a", mul_a, 32'd6);
        repeat (8) @(negedge clk);
        chk("rod_result", result0, 32'd13);

        // Watchdog: the multiplier never answers.
        mul_en = 1'b0;
        do_req(1'b0, 32'd5, 32'd5, iss, dn, ma, mb, res, bok);
        chk("wd_done_after_issue", 64'(dn - iss), 64'd9);
        chk("wd_result", res, 32'd0);
        chk("wd_timeout", timeout, 1'b1);
        chk("wd_busy", bok, 1'b1);
        mul_en = 1'b1;
        do_req(1'b1, 32'd2, 32'd3, iss, dn, ma, mb, res, bok);
        chk("wd_next_result", res, 32'd5);
        chk("wd_sticky", timeout, 1'b1);

        // Reset in the second WAIT cycle. The stale multiplier done arrives later.
        @(negedge clk);
        start0 = 1'b1; a0 = 32'd2; b0 = 32'd2;
        @(negedge clk);
        start0 = 1'b0;
        ti = -1;
        for (int k = 0; k < 10; k++) begin
            if (mul_start) begin ti = cyc; break; end
            @(negedge clk);
        end
        chk("rw_issued", 64'(ti >= 0), 64'd1);
        repeat (2) @(negedge clk);           // now in WAIT cycle 2
        base_s = n_start; base_d = n_done0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("rw_no_done", 64'(n_done0 - base_d), 64'd0);
        chk("rw_no_issue", 64'(n_start - base_s), 64'd0);
        chk("rw_flags", {busy0, busy1, done0, done1, mul_start, timeout}, 64'd0);
        chk("rw_results", {result0, result1}, 64'd0);
        chk("rw_mul_ops", {mul_a, mul_b}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
